// File: rtl/mandel_iter_scheduler.sv
// Frame scheduler: walks the pixel raster and dispatches each pixel's c value
// to a free iterator. Finished counts are collected round-robin and presented
// as (x, y, count) tagged pixels to the pixel-memory writer.
module mandel_iter_scheduler #(
  parameter int NUM_ITER = 4,
  parameter int H_RES    = 640,
  parameter int V_RES    = 480,
  parameter int CNT_W    = 10,
  parameter int X_W      = $clog2(H_RES),
  parameter int Y_W      = $clog2(V_RES)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [26:0]               c_r_start,
  input  logic [26:0]               c_i_start,
  input  logic [26:0]               dc_r,
  input  logic [26:0]               dc_i,
  output logic                      busy,
  output logic                      done,
  output logic [26:0]               it_c_r,
  output logic [26:0]               it_c_i,
  output logic [NUM_ITER-1:0]       it_in_val,
  input  logic [NUM_ITER-1:0]       it_in_rdy,
  input  logic [NUM_ITER-1:0]       it_out_val,
  output logic [NUM_ITER-1:0]       it_out_rdy,
  input  logic [NUM_ITER*CNT_W-1:0] it_iter_count,
  output logic                      px_val,
  input  logic                      px_rdy,
  output logic [X_W-1:0]            px_x,
  output logic [Y_W-1:0]            px_y,
  output logic [CNT_W-1:0]          px_iter
);

  localparam int RR_W = (NUM_ITER > 1) ? $clog2(NUM_ITER) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_FIN} state_t;

  state_t              state_q, state_d;
  logic [26:0]         c_r0_q, c_r0_d;
  logic [26:0]         dc_r_q, dc_r_d;
  logic [26:0]         dc_i_q, dc_i_d;
  logic [26:0]         cur_r_q, cur_r_d;
  logic [26:0]         cur_i_q, cur_i_d;
  logic [X_W-1:0]      x_q, x_d;
  logic [Y_W-1:0]      y_q, y_d;
  logic [NUM_ITER-1:0] owned_q, owned_d;
  logic [RR_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic                px_val_q, px_val_d;
  logic [X_W-1:0]      px_x_q, px_x_d;
  logic [Y_W-1:0]      px_y_q, px_y_d;
  logic [CNT_W-1:0]    px_iter_q, px_iter_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [X_W-1:0]      tag_x_q [NUM_ITER];
  logic [X_W-1:0]      tag_x_d [NUM_ITER];
  logic [Y_W-1:0]      tag_y_q [NUM_ITER];
  logic [Y_W-1:0]      tag_y_d [NUM_ITER];

  logic [NUM_ITER-1:0] free_set, disp;
  logic                disp_found;
  logic [NUM_ITER-1:0] cand, grant;
  logic                grant_found;

  // Dispatch: lowest-index iterator that is ready and not already holding work.
  always_comb begin
    // NOTE: every signal assigned in a combinational block gets a default
    // first, so no path can leave it holding its old value (no latch).
    free_set   = it_in_rdy & ~owned_q;
    disp       = '0;
    disp_found = 1'b0;
    if (state_q == S_RUN) begin
      for (int i = 0; i < NUM_ITER; i++) begin
        if (!disp_found && free_set[i]) begin
          disp_found = 1'b1;
          disp[i]    = 1'b1;
        end
      end
    end
  end

  // Collection: first owned, valid iterator at or after rr_ptr, when the output slot frees up.
  always_comb begin
    cand        = it_out_val & owned_q;
    grant       = '0;
    grant_found = 1'b0;
    if ((state_q == S_RUN || state_q == S_DRAIN) && (!px_val_q || px_rdy)) begin
      for (int i = 0; i < NUM_ITER; i++) begin
        if (!grant_found && cand[i] && (RR_W'(i) >= rr_ptr_q)) begin
          grant_found = 1'b1;
          grant[i]    = 1'b1;
        end
      end
      for (int i = 0; i < NUM_ITER; i++) begin
        if (!grant_found && cand[i]) begin
          grant_found = 1'b1;
          grant[i]    = 1'b1;
        end
      end
    end
  end

  // Next-state: raster walk, ownership, output slot and FSM.
  always_comb begin
    state_d   = state_q;
    c_r0_d    = c_r0_q;
    dc_r_d    = dc_r_q;
    dc_i_d    = dc_i_q;
    cur_r_d   = cur_r_q;
    cur_i_d   = cur_i_q;
    x_d       = x_q;
    y_d       = y_q;
    rr_ptr_d  = rr_ptr_q;
    px_val_d  = px_val_q;
    px_x_d    = px_x_q;
    px_y_d    = px_y_q;
    px_iter_d = px_iter_q;
    tag_x_d   = tag_x_q;
    tag_y_d   = tag_y_q;

    // Dispatch and grant never touch the same iterator: one needs ~owned, the other owned.
    owned_d = (owned_q | disp) & ~grant;

    for (int i = 0; i < NUM_ITER; i++) begin
      if (disp[i]) begin
        tag_x_d[i] = x_q;
        tag_y_d[i] = y_q;
      end
    end

    if (px_val_q && px_rdy) px_val_d = 1'b0;
    for (int i = 0; i < NUM_ITER; i++) begin
      if (grant[i]) begin
        px_val_d  = 1'b1;
        px_x_d    = tag_x_q[i];
        px_y_d    = tag_y_q[i];
        px_iter_d = it_iter_count[i*CNT_W +: CNT_W];
        rr_ptr_d  = RR_W'((i + 1) % NUM_ITER);
      end
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          // c_i_start needs no copy of its own: cur_i carries it and is never rewound.
          c_r0_d  = c_r_start;
          dc_r_d  = dc_r;
          dc_i_d  = dc_i;
          cur_r_d = c_r_start;
          cur_i_d = c_i_start;
          x_d     = '0;
          y_d     = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (disp_found) begin
          if (x_q == X_W'(H_RES - 1)) begin
            x_d     = '0;
            cur_r_d = c_r0_q;
            y_d     = y_q + 1'b1;
            cur_i_d = cur_i_q + dc_i_q;
            if (y_q == Y_W'(V_RES - 1)) state_d = S_DRAIN;
          end else begin
            x_d     = x_q + 1'b1;
            cur_r_d = cur_r_q + dc_r_q;
          end
        end
      end
      S_DRAIN: begin
        // Looking at next-cycle values lets done rise the cycle after the last handshake.
        if (owned_d == '0 && !px_val_d) state_d = S_FIN;
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d == S_RUN) || (state_d == S_DRAIN);
    done_d = (state_d == S_FIN);
  end

  // Control and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (!reset) begin
      state_q   <= S_IDLE;
      c_r0_q    <= '0;
      dc_r_q    <= '0;
      dc_i_q    <= '0;
      cur_r_q   <= '0;
      cur_i_q   <= '0;
      x_q       <= '0;
      y_q       <= '0;
      owned_q   <= '0;
      rr_ptr_q  <= '0;
      px_val_q  <= 1'b0;
      px_x_q    <= '0;
      px_y_q    <= '0;
      px_iter_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      c_r0_q    <= c_r0_d;
      dc_r_q    <= dc_r_d;
      dc_i_q    <= dc_i_d;
      cur_r_q   <= cur_r_d;
      cur_i_q   <= cur_i_d;
      x_q       <= x_d;
      y_q       <= y_d;
      owned_q   <= owned_d;
      rr_ptr_q  <= rr_ptr_d;
      px_val_q  <= px_val_d;
      px_x_q    <= px_x_d;
      px_y_q    <= px_y_d;
      px_iter_q <= px_iter_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  // Per-iterator pixel tags.
  always_ff @(posedge clk) begin
    // NOTE: the tag table is left out of reset on purpose; an entry is only
    // read while its owned bit is set, and owned is always written first.
    tag_x_q <= tag_x_d;
    tag_y_q <= tag_y_d;
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign it_c_r     = cur_r_q;
  assign it_c_i     = cur_i_q;
  assign it_in_val  = disp;
  assign it_out_rdy = grant;
  assign px_val     = px_val_q;
  assign px_x       = px_x_q;
  assign px_y       = px_y_q;
  assign px_iter    = px_iter_q;

endmodule

// File: tb/tb_mandel_iter_scheduler.sv
// Bench for mandel_iter_scheduler: 4x2 frame, two modelled iterators with
// programmable latency/result, and a cycle-level reference scoreboard.
module tb_mandel_iter_scheduler;

  localparam int N   = 2;
  localparam int H   = 4;
  localparam int V   = 2;
  localparam int CW  = 10;
  localparam int XW  = $clog2(H);
  localparam int YW  = $clog2(V);

  // Q4.23 constants
  localparam logic [26:0] CR0 = 27'h7000000;  // -2.0
  localparam logic [26:0] CI0 = 27'h7800000;  // -1.0
  localparam logic [26:0] DCR = 27'h0400000;  // +0.5
  localparam logic [26:0] DCI = 27'h0800000;  // +1.0

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [26:0]       c_r_start, c_i_start, dc_r, dc_i;
  logic              busy, done;
  logic [26:0]       it_c_r, it_c_i;
  logic [N-1:0]      it_in_val, it_in_rdy, it_out_val, it_out_rdy;
  logic [N*CW-1:0]   it_iter_count;
  logic              px_val, px_rdy;
  logic [XW-1:0]     px_x;
  logic [YW-1:0]     px_y;
  logic [CW-1:0]     px_iter;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mandel_iter_scheduler #(
    .NUM_ITER(N), .H_RES(H), .V_RES(V), .CNT_W(CW)
  ) dut (
    .clk(clk), .reset(reset), .start(start),
    .c_r_start(c_r_start), .c_i_start(c_i_start), .dc_r(dc_r), .dc_i(dc_i),
    .busy(busy), .done(done),
    .it_c_r(it_c_r), .it_c_i(it_c_i),
    .it_in_val(it_in_val), .it_in_rdy(it_in_rdy),
    .it_out_val(it_out_val), .it_out_rdy(it_out_rdy),
    .it_iter_count(it_iter_count),
    .px_val(px_val), .px_rdy(px_rdy),
    .px_x(px_x), .px_y(px_y), .px_iter(px_iter)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- iterator models ----------------
  int           lat [N];
  logic [CW-1:0] res [N];
  int           rem [N];
  logic [N-1:0] m_run, m_done;

  always @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (!reset) begin
        m_run[i]  <= 1'b0;
        m_done[i] <= 1'b0;
        rem[i]    <= 0;
      end else if (it_in_val[i] && it_in_rdy[i]) begin
        m_run[i] <= 1'b1;
        rem[i]   <= lat[i];
      end else if (m_run[i]) begin
        if (rem[i] <= 1) begin
          m_run[i]  <= 1'b0;
          m_done[i] <= 1'b1;
        end else begin
          rem[i] <= rem[i] - 1;
        end
      end else if (m_done[i] && it_out_rdy[i]) begin
        m_done[i] <= 1'b0;
      end
    end
  end

  assign it_in_rdy  = ~(m_run | m_done);
  assign it_out_val = m_done;
  for (genvar g = 0; g < N; g++) begin : g_cnt
    assign it_iter_count[g*CW +: CW] = res[g];
  end

  // ---------------- reference scoreboard (sampled on negedge) ----------------
  typedef enum {P_IDLE, P_RUN, P_DRAIN, P_FIN} phase_t;
  phase_t        b_phase = P_IDLE;
  logic [N-1:0]  b_owned = '0;
  int            b_rr = 0, bx = 0, by = 0;
  int            tag_bx [N];
  int            tag_by [N];
  logic          b_pxv = 1'b0;
  int            b_pxx = 0, b_pxy = 0;
  logic [CW-1:0] b_pxi = '0;
  logic [26:0]   b_cr0 = '0, b_ci0 = '0, b_dcr = '0, b_dci = '0;
  int            hs_cnt = 0, done_cnt = 0, disp_cnt = 0, both_cnt = 0, stall_cnt = 0;
  int            seen [H][V];
  int            grants [N];

  always @(negedge clk) begin : mon
    logic [N-1:0] free_m, exp_in, cand_m, exp_out, nxt_owned;
    logic         slot_free;
    int           pick, idx;
    logic [26:0]  ecr, eci;
    if (!reset) begin
      b_phase = P_IDLE;
      b_owned = '0;
      b_pxv   = 1'b0;
      b_rr    = 0;
    end else begin
      check("busy", 64'(busy), 64'(b_phase == P_RUN || b_phase == P_DRAIN));
      check("done", 64'(done), 64'(b_phase == P_FIN));
      if (done) done_cnt++;

      nxt_owned = b_owned;
      free_m = it_in_rdy & ~b_owned;
      exp_in = '0;
      if (b_phase == P_RUN)
        for (int i = N - 1; i >= 0; i--) if (free_m[i]) begin exp_in = '0; exp_in[i] = 1'b1; end
      check("it_in_val", 64'(it_in_val), 64'(exp_in));
      if (exp_in != '0) begin
        ecr = b_cr0 + 27'(bx) * b_dcr;
        eci = b_ci0 + 27'(by) * b_dci;
        check("it_c_r", 64'(it_c_r), 64'(ecr));
        check("it_c_i", 64'(it_c_i), 64'(eci));
        for (int i = 0; i < N; i++) if (exp_in[i]) begin
          tag_bx[i] = bx; tag_by[i] = by; nxt_owned[i] = 1'b1;
        end
        disp_cnt++;
        if (bx == H - 1) begin
          bx = 0;
          if (by == V - 1) b_phase = P_DRAIN;
          by++;
        end else begin
          bx++;
        end
      end

      cand_m    = it_out_val & b_owned;
      slot_free = !b_pxv || px_rdy;
      exp_out   = '0;
      pick      = -1;
      if ((b_phase == P_RUN || b_phase == P_DRAIN || exp_in != '0) && slot_free)
        for (int k = 0; k < N; k++) begin
          idx = (b_rr + k) % N;
          if (pick < 0 && cand_m[idx]) pick = idx;
        end
      if (cand_m == {N{1'b1}} && slot_free) both_cnt++;
      if (pick >= 0) exp_out[pick] = 1'b1;
      check("it_out_rdy", 64'(it_out_rdy), 64'(exp_out));

      check("px_val", 64'(px_val), 64'(b_pxv));
      if (b_pxv) begin
        check("px_x", 64'(px_x), 64'(b_pxx));
        check("px_y", 64'(px_y), 64'(b_pxy));
        check("px_iter", 64'(px_iter), 64'(b_pxi));
        if (px_rdy) begin
          hs_cnt++;
          seen[b_pxx][b_pxy]++;
        end else begin
          stall_cnt++;
        end
      end

      if (pick >= 0) begin
        b_pxv = 1'b1;
        b_pxx = tag_bx[pick];
        b_pxy = tag_by[pick];
        b_pxi = res[pick];
        nxt_owned[pick] = 1'b0;
        b_rr = (pick + 1) % N;
        grants[pick]++;
      end else if (b_pxv && px_rdy) begin
        b_pxv = 1'b0;
      end
      b_owned = nxt_owned;

      case (b_phase)
        P_IDLE: if (start) begin
          b_phase = P_RUN;
          b_cr0 = c_r_start; b_ci0 = c_i_start; b_dcr = dc_r; b_dci = dc_i;
          bx = 0; by = 0;
          hs_cnt = 0; done_cnt = 0; disp_cnt = 0; both_cnt = 0; stall_cnt = 0;
          for (int i = 0; i < N; i++) grants[i] = 0;
          for (int x = 0; x < H; x++) for (int y = 0; y < V; y++) seen[x][y] = 0;
        end
        P_DRAIN: if (b_owned == '0 && !b_pxv) b_phase = P_FIN;
        P_FIN:   b_phase = P_IDLE;
        default: ;
      endcase
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    reset = 1'b1;
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (done_cnt == 0 && n < 300) begin
      tick();
      n++;
    end
    check({tag, "_done_seen"}, 64'(done_cnt > 0), 64'd1);
  endtask

  task automatic check_frame(input string tag);
    tick();
    check({tag, "_px_count"}, 64'(hs_cnt), 64'd8);
    check({tag, "_done_count"}, 64'(done_cnt), 64'd1);
    check({tag, "_busy_after"}, 64'(busy), 64'd0);
    for (int x = 0; x < H; x++)
      for (int y = 0; y < V; y++)
        check($sformatf("%s_seen_%0d_%0d", tag, x, y), 64'(seen[x][y]), 64'd1);
  endtask

  initial begin : stim
    int n;
    reset = 1'b0; start = 1'b0; px_rdy = 1'b1;
    c_r_start = CR0; c_i_start = CI0; dc_r = DCR; dc_i = DCI;
    lat[0] = 3; lat[1] = 3; res[0] = 10'd5; res[1] = 10'd5;
    tick();
    tick();
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_px_val", 64'(px_val), 64'd0);
    check("rst_in_val", 64'(it_in_val), 64'd0);
    check("rst_out_rdy", 64'(it_out_rdy), 64'd0);
    reset = 1'b1;
    tick();

    // A: basic frame, fixed count 5 after 3 cycles
    pulse_start();
    check("A_busy_run", 64'(busy), 64'd1);
    check("A_first_cr", 64'(it_c_r), 64'(CR0));
    wait_done("A");
    check_frame("A");

    // B: skewed latencies, distinct counts per iterator
    lat[0] = 10; lat[1] = 2; res[0] = 10'd7; res[1] = 10'd9;
    pulse_start();
    wait_done("B");
    check_frame("B");
    check("B_it1_multi", 64'(grants[1] > 1), 64'd1);

    // C: simultaneous completion with rr_ptr at 0
    do_reset();
    lat[0] = 4; lat[1] = 3; res[0] = 10'd5; res[1] = 10'd6;
    pulse_start();
    wait_done("C");
    check_frame("C");
    check("C_both_seen", 64'(both_cnt > 0), 64'd1);

    // D: writer stalls for 6 cycles mid-frame
    lat[0] = 3; lat[1] = 3; res[0] = 10'd5; res[1] = 10'd3;
    pulse_start();
    repeat (5) tick();
    px_rdy = 1'b0;
    repeat (6) tick();
    px_rdy = 1'b1;
    wait_done("D");
    check("D_stall_hold", 64'(stall_cnt >= 5), 64'd1);
    check_frame("D");

    // E: reset after 3 dispatches, then a fresh frame with a stray start mid-run
    pulse_start();
    n = 0;
    while (disp_cnt < 3 && n < 100) begin tick(); n++; end
    check("E_three_disp", 64'(disp_cnt >= 3), 64'd1);
    do_reset();
    check("E_rst_busy", 64'(busy), 64'd0);
    check("E_rst_px_val", 64'(px_val), 64'd0);
    check("E_rst_out_rdy", 64'(it_out_rdy), 64'd0);
    tick();
    pulse_start();
    tick();
    c_r_start = 27'h0123456; dc_r = 27'h0000001; c_i_start = 27'h0654321; dc_i = 27'h0000002;
    start = 1'b1;
    tick();
    start = 1'b0;
    c_r_start = CR0; c_i_start = CI0; dc_r = DCR; dc_i = DCI;
    wait_done("E");
    check_frame("E");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
